alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares the single 16-bit ALU datapath between two requesters, e.g. requester 0 = main instruction datapath and requester 1 = address/branch unit.
- Uses a req/gnt/done handshake with round-robin arbitration.
- Latches the winner's operands and opcode, drives the ALU for a fixed op-dependent latency, then returns the registered result and zero flag.
- Sits between the requesters and the ALU instance; it is the only driver of the ALU inputs.

Parameters:
- WIDTH, 16, operand/result width; must match the ALU.
- FAST_LAT, 1, EXEC cycles for ops 0000, 0001 and 0101–1101.
- SLOW_LAT, 4, EXEC cycles for ops 0010 mult, 0011 div and 0100 mod; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  synchronous, active-low reset
- req0  in  1  requester 0 request; held with op0/a0/b0 stable until done0
- op0  in  4  requester 0 opcode (ALU selector encoding)
- a0  in  WIDTH  requester 0 operand a
- b0  in  WIDTH  requester 0 operand b
- gnt0  out  1  one-cycle pulse: requester 0 accepted
- done0  out  1  one-cycle pulse: result/zero valid for requester 0
- req1, op1, a1, b1, gnt1, done1: same as above, for requester 1
- alu_a  out  WIDTH  to ALU a
- alu_b  out  WIDTH  to ALU b
- alu_sel  out  4  to ALU selector
- alu_result  in  WIDTH  from ALU result
- alu_zero  in  1  from ALU zero (a−b==0)
- result  out  WIDTH  registered result, held until next completion
- zero  out  1  registered zero flag, held with result
- busy  out  1  high in EXEC and DONE

Behaviour:
- Reset (reset_n low at a clk edge, any state, including mid-operation):
  - state=IDLE; rr pointer=0 (requester 0 favoured).
  - gnt*, done*, busy, result, zero, alu_a and alu_b = 0; alu_sel = 4'b1111.
  - Any in-flight operation is dropped and no done is emitted.
- FSM IDLE → EXEC → DONE → IDLE. All outputs are registered.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: grant it.
  - Both reqs: grant the requester indicated by rr; on grant, rr flips to the other requester.
  - On the grant edge: latch op/a/b of the winner; load counter with SLOW_LAT for 0010–0100, else FAST_LAT; go to EXEC.
- EXEC:
  - gntN=1 in the first EXEC cycle only.
  - alu_a/alu_b/alu_sel driven from latches, stable for the whole state.
  - Counter decrements each cycle. On the edge where counter==1: capture alu_result→result and alu_zero→zero; go to DONE.
- DONE: doneN=1 for exactly one cycle; busy=1; next state IDLE.
- Outside EXEC, alu_sel=4'b1111. Every operation therefore presents a selector change to the ALU, whose evaluation is selector-triggered.
- Illegal opcodes 1110/1111:
  - Latency FAST_LAT; the ALU is not driven (alu_sel stays 1111).
  - result=0, zero=0 at completion.
- Latency: req seen at edge E → gnt in cycle E+1 → done in cycle E+1+LAT.
  - Fast op: done 2 cycles after the request edge.
  - Slow op (default): done 5 cycles after the request edge.
- Requester rules:
  - Request inputs are ignored during EXEC/DONE.
  - req still high at the IDLE edge after done is a new request.
  - Back-to-back throughput: one op per LAT+2 cycles.
- Requests arriving while busy wait; nothing is lost, because req is level and held.

Optional Feature:
- Macro: ALU_ARB_ILLEGAL_ERR_EN.
- When defined:
  - Adds output port err (1 bit), registered, reset 0.
  - err=1 alongside done when the completed op was 1110/1111, else err=0.
  - err holds until the next completion.
- When undefined: no err port; illegal ops still complete as specified above.

Test Plan:
- Reset then req0, op0=0000, a0=16'h0003, b0=16'h0005 → gnt0 next cycle; done0 one cycle later; result=16'h0008, zero=0.
- req1, op1=0010, a1=7, b1=6 (SLOW_LAT=4) → done1 exactly 5 cycles after the request edge; result=42; busy high for those 5 cycles.
- req0 and req1 both high, held continuously, both op=0001 with a=b=9 → served in order 0,1,0,1; each result=0, zero=1; no starvation.
- Assert reset_n=0 in the 2nd EXEC cycle of a div → next cycle all outputs 0, no done pulse; a fresh request after release is served normally, requester 0 first.
- op0=1111, a0=16'hFFFF → done0 after FAST_LAT, result=0, alu_sel never leaves 1111; with ALU_ARB_ILLEGAL_ERR_EN defined, err=1.
- op0=1100, a0=16'h8001 then op0=1101, a0=16'h8001 → results 16'h0002 then 16'h4000; alu_sel observed passing through 1111 between the two ops.

Source files
------------

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one ALU between two requesters
// Optional macro ALU_ARB_ILLEGAL_ERR_EN adds the err output for opcodes 1110/1111.
module alu_arbiter #(
    parameter int WIDTH    = 16,
    parameter int FAST_LAT = 1,
    parameter int SLOW_LAT = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             req0,
    input  logic [3:0]       op0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    output logic             gnt0,
    output logic             done0,
    input  logic             req1,
    input  logic [3:0]       op1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt1,
    output logic             done1,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_zero,
    output logic [WIDTH-1:0] result,
    output logic             zero,
`ifdef ALU_ARB_ILLEGAL_ERR_EN
    output logic             err,
`endif
    output logic             busy
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

    state_t           state_q, state_d;
    logic             rr_q, rr_d;
    logic             who_q, who_d;
    logic             ill_q, ill_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [3:0]       alu_sel_q, alu_sel_d;
    logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic             done0_q, done0_d, done1_q, done1_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
`ifdef ALU_ARB_ILLEGAL_ERR_EN
    logic             err_q, err_d;
`endif

    // Winner selection: rr_q only matters when both requesters contend.
    logic             win1;
    logic [3:0]       op_w;
    logic [WIDTH-1:0] a_w, b_w;
    logic             ill_w;
    logic             slow_w;

    always_comb begin
        win1   = req1 & (~req0 | rr_q);
        op_w   = win1 ? op1 : op0;
        a_w    = win1 ? a1 : a0;
        b_w    = win1 ? b1 : b0;
        ill_w  = (op_w[3:1] == 3'b111);
        slow_w = (op_w == 4'b0010) || (op_w == 4'b0011) || (op_w == 4'b0100);
    end

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        who_d     = who_q;
        ill_d     = ill_q;
        cnt_d     = cnt_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_sel_d = alu_sel_q;
        gnt0_d    = 1'b0;
        gnt1_d    = 1'b0;
        done0_d   = 1'b0;
        done1_d   = 1'b0;
        busy_d    = busy_q;
        result_d  = result_q;
        zero_d    = zero_q;
`ifdef ALU_ARB_ILLEGAL_ERR_EN
        err_d     = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    if (req0 && req1) rr_d = ~win1;
                    who_d     = win1;
                    ill_d     = ill_w;
                    cnt_d     = slow_w ? 4'(SLOW_LAT) : 4'(FAST_LAT);
                    alu_a_d   = ill_w ? '0 : a_w;
                    alu_b_d   = ill_w ? '0 : b_w;
                    alu_sel_d = ill_w ? 4'b1111 : op_w;
                    gnt0_d    = ~win1;
                    gnt1_d    = win1;
                    busy_d    = 1'b1;
                    state_d   = S_EXEC;
                end
            end
            S_EXEC: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    result_d  = ill_q ? '0 : alu_result;
                    zero_d    = ill_q ? 1'b0 : alu_zero;
`ifdef ALU_ARB_ILLEGAL_ERR_EN
                    err_d     = ill_q;
`endif
                    done0_d   = ~who_q;
                    done1_d   = who_q;
                    alu_a_d   = '0;
                    alu_b_d   = '0;
                    alu_sel_d = 4'b1111;
                    state_d   = S_DONE;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            rr_q      <= 1'b0;
            who_q     <= 1'b0;
            ill_q     <= 1'b0;
            cnt_q     <= '0;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_sel_q <= 4'b1111;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            done0_q   <= 1'b0;
            done1_q   <= 1'b0;
            busy_q    <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b0;
`ifdef ALU_ARB_ILLEGAL_ERR_EN
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            who_q     <= who_d;
            ill_q     <= ill_d;
            cnt_q     <= cnt_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_sel_q <= alu_sel_d;
            gnt0_q    <= gnt0_d;
            gnt1_q    <= gnt1_d;
            done0_q   <= done0_d;
            done1_q   <= done1_d;
            busy_q    <= busy_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
`ifdef ALU_ARB_ILLEGAL_ERR_EN
            err_q     <= err_d;
`endif
        end
    end

    assign gnt0    = gnt0_q;
    assign gnt1    = gnt1_q;
    assign done0   = done0_q;
    assign done1   = done1_q;
    assign alu_a   = alu_a_q;
    assign alu_b   = alu_b_q;
    assign alu_sel = alu_sel_q;
    assign result  = result_q;
    assign zero    = zero_q;
    assign busy    = busy_q;
`ifdef ALU_ARB_ILLEGAL_ERR_EN
    assign err     = err_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req0, req1;
    logic [3:0]  op0, op1;
    logic [15:0] a0, b0, a1, b1;
    logic        gnt0, gnt1, done0, done1;
    logic [15:0] alu_a, alu_b, alu_result, result;
    logic [3:0]  alu_sel;
    logic        alu_zero, zero, busy;
`ifdef ALU_ARB_ILLEGAL_ERR_EN
    logic        err;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .req0(req0), .op0(op0), .a0(a0), .b0(b0), .gnt0(gnt0), .done0(done0),
        .req1(req1), .op1(op1), .a1(a1), .b1(b1), .gnt1(gnt1), .done1(done1),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .result(result), .zero(zero),
`ifdef ALU_ARB_ILLEGAL_ERR_EN
        .err(err),
`endif
        .busy(busy)
    );

    // Behavioural ALU standing in for the real datapath
    always_comb begin
        case (alu_sel)
            4'b0000: alu_result = alu_a + alu_b;
            4'b0001: alu_result = alu_a - alu_b;
            4'b0010: alu_result = alu_a * alu_b;
            4'b0011: alu_result = (alu_b == 16'd0) ? 16'd0 : alu_a / alu_b;
            4'b0100: alu_result = (alu_b == 16'd0) ? 16'd0 : alu_a % alu_b;
            4'b0101: alu_result = alu_a & alu_b;
            4'b0110: alu_result = alu_a | alu_b;
            4'b0111: alu_result = alu_a ^ alu_b;
            4'b1100: alu_result = alu_a << 1;
            4'b1101: alu_result = alu_a >> 1;
            default: alu_result = 16'h0000;
        endcase
        alu_zero = ((alu_a - alu_b) == 16'd0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_gnt0"}, 32'(gnt0), 32'd0);
        chk({tag, "_gnt1"}, 32'(gnt1), 32'd0);
        chk({tag, "_done0"}, 32'(done0), 32'd0);
        chk({tag, "_done1"}, 32'(done1), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_sel"}, 32'(alu_sel), 32'hF);
    endtask

    // Single uncontended operation; request drops on the done cycle
    task automatic run_op(input int who, input logic [3:0] op, input logic [15:0] a,
                          input logic [15:0] b, input int lat,
                          input logic [15:0] er, input logic ez);
        logic ill;
        ill = (op[3:1] == 3'b111);
        if (who == 0) begin req0 = 1'b1; op0 = op; a0 = a; b0 = b; end
        else          begin req1 = 1'b1; op1 = op; a1 = a; b1 = b; end
        for (int c = 1; c <= lat + 1; c++) begin
            tick();
            chk("op_gnt0", 32'(gnt0), 32'(who == 0 && c == 1));
            chk("op_gnt1", 32'(gnt1), 32'(who == 1 && c == 1));
            chk("op_done0", 32'(done0), 32'(who == 0 && c == lat + 1));
            chk("op_done1", 32'(done1), 32'(who == 1 && c == lat + 1));
            chk("op_busy", 32'(busy), 32'd1);
            chk("op_sel", 32'(alu_sel), (c <= lat && !ill) ? 32'(op) : 32'hF);
            if (c == lat + 1) begin
                chk("op_result", 32'(result), 32'(er));
                chk("op_zero", 32'(zero), 32'(ez));
`ifdef ALU_ARB_ILLEGAL_ERR_EN
                chk("op_err", 32'(err), 32'(ill));
`endif
                req0 = 1'b0;
                req1 = 1'b0;
            end
        end
        tick();
        chk_idle_outputs("op_after");
    endtask

    initial begin
        reset_n = 1'b0;
        req0 = 1'b0; op0 = 4'h0; a0 = 16'h0; b0 = 16'h0;
        req1 = 1'b0; op1 = 4'h0; a1 = 16'h0; b1 = 16'h0;
        tick();
        tick();
        chk_idle_outputs("reset");
        chk("reset_result", 32'(result), 32'd0);
        chk("reset_alu_a", 32'(alu_a), 32'd0);
        reset_n = 1'b1;
        tick();
        chk_idle_outputs("post_reset");

        // Fast add: 3 + 5
        run_op(0, 4'b0000, 16'h0003, 16'h0005, 1, 16'h0008, 1'b0);
        // Slow multiply on requester 1: 7 * 6
        run_op(1, 4'b0010, 16'd7, 16'd6, 4, 16'd42, 1'b0);

        // Contention: both held, served 0,1,0,1
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        req0 = 1'b1; op0 = 4'b0001; a0 = 16'd9; b0 = 16'd9;
        req1 = 1'b1; op1 = 4'b0001; a1 = 16'd9; b1 = 16'd9;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_gnt0", 32'(gnt0), 32'(k % 2 == 0));
            chk("rr_gnt1", 32'(gnt1), 32'(k % 2 == 1));
            tick();
            chk("rr_done0", 32'(done0), 32'(k % 2 == 0));
            chk("rr_done1", 32'(done1), 32'(k % 2 == 1));
            chk("rr_result", 32'(result), 32'd0);
            chk("rr_zero", 32'(zero), 32'd1);
            tick();
            chk("rr_idle_busy", 32'(busy), 32'd0);
        end
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        tick();

        // Reset during the second EXEC cycle of a contended div
        req0 = 1'b1; op0 = 4'b0011; a0 = 16'd100; b0 = 16'd7;
        req1 = 1'b1; op1 = 4'b0011; a1 = 16'd50;  b1 = 16'd7;
        tick();
        chk("mid_gnt0", 32'(gnt0), 32'd1);
        tick();
        chk("mid_exec2_busy", 32'(busy), 32'd1);
        reset_n = 1'b0;
        tick();
        chk_idle_outputs("mid_reset");
        chk("mid_result", 32'(result), 32'd0);
        chk("mid_zero", 32'(zero), 32'd0);
        chk("mid_alu_a", 32'(alu_a), 32'd0);
        chk("mid_alu_b", 32'(alu_b), 32'd0);
        reset_n = 1'b1;
        // rr returned to 0, so requester 0 wins again
        for (int c = 1; c <= 5; c++) begin
            tick();
            chk("rst_gnt0", 32'(gnt0), 32'(c == 1));
            chk("rst_gnt1", 32'(gnt1), 32'd0);
            chk("rst_done0", 32'(done0), 32'(c == 5));
            chk("rst_done1", 32'(done1), 32'd0);
        end
        chk("rst_result", 32'(result), 32'd14);
        req0 = 1'b0;
        req1 = 1'b0;
        tick();
        tick();

        // Illegal opcode: ALU untouched, result/zero forced to 0
        run_op(0, 4'b1111, 16'hFFFF, 16'h0000, 1, 16'h0000, 1'b0);

        // Shifts, with alu_sel returning to 1111 between them
        run_op(0, 4'b1100, 16'h8001, 16'h0000, 1, 16'h0002, 1'b0);
        run_op(0, 4'b1101, 16'h8001, 16'h0000, 1, 16'h4000, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
